arf_status_ctrl: RTL and testbench

Controller for the 16-entry architecture register file (ARF) in the superscalar core. It holds the per-register busy bit and producer tag. It sequences the single ARF write port: a zero-fill sweep after reset, then in-order commit writes. Dispatch and commit logic sit on either side; the ARF write port is driven only by this block.

---
 rtl/arf_status_ctrl_if.sv | 55 +++++
 rtl/arf_status_ctrl.sv | 140 ++++++++++++++
 tb/tb_arf_status_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/arf_status_ctrl_if.sv
// ARF status controller bus: dispatch, commit, flush, operand lookup and
// the ARF write port. The controller is the slave; dispatch/commit/ARF
// side is the master.
interface arf_status_ctrl_if #(
   parameter int REG_ADDR_W = 4,
   parameter int TAG_W      = 4,
   parameter int DATA_W     = 32
) ();
   logic                  dispatch_valid;
   logic [REG_ADDR_W-1:0] dispatch_reg;
   logic [TAG_W-1:0]      dispatch_tag;
   logic                  dispatch_ready;

   logic                  commit_valid;
   logic [REG_ADDR_W-1:0] commit_reg;
   logic [TAG_W-1:0]      commit_tag;
   logic [DATA_W-1:0]     commit_data;
   logic                  commit_ready;

   logic                  flush;

   logic [REG_ADDR_W-1:0] lookup_reg1;
   logic [REG_ADDR_W-1:0] lookup_reg2;
   logic                  lookup_busy1;
   logic                  lookup_busy2;
   logic [TAG_W-1:0]      lookup_tag1;
   logic [TAG_W-1:0]      lookup_tag2;

   logic                  arf_write_enable;
   logic [REG_ADDR_W-1:0] arf_write_reg;
   logic [DATA_W-1:0]     arf_write_data;
   logic                  init_done;

   modport slave (
      input  dispatch_valid, dispatch_reg, dispatch_tag,
      output dispatch_ready,
      input  commit_valid, commit_reg, commit_tag, commit_data,
      output commit_ready,
      input  flush,
      input  lookup_reg1, lookup_reg2,
      output lookup_busy1, lookup_busy2, lookup_tag1, lookup_tag2,
      output arf_write_enable, arf_write_reg, arf_write_data, init_done
   );

   modport master (
      output dispatch_valid, dispatch_reg, dispatch_tag,
      input  dispatch_ready,
      output commit_valid, commit_reg, commit_tag, commit_data,
      input  commit_ready,
      output flush,
      output lookup_reg1, lookup_reg2,
      input  lookup_busy1, lookup_busy2, lookup_tag1, lookup_tag2,
      input  arf_write_enable, arf_write_reg, arf_write_data, init_done
   );
endinterface

// File: rtl/arf_status_ctrl.sv
// arf_status_ctrl: busy/tag scoreboard for the 16-entry ARF and sequencer of
// the single ARF write port (zero-fill sweep after reset, then commit writes).
// Optional macro ARF_COMMIT_BYPASS_EN: lookup forwards a same-cycle matching
// commit so the operand already reads not-busy.
module arf_status_ctrl #(
   parameter int NUM_REGS   = 16,
   parameter int REG_ADDR_W = 4,
   parameter int TAG_W      = 4,
   parameter int DATA_W     = 32
) (
   input logic              clk,
   input logic              reset,
   arf_status_ctrl_if.slave bus
);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

   state_e                         state_q, state_d;
   logic [REG_ADDR_W-1:0]          cnt_q, cnt_d;
   logic                           init_done_q, init_done_d;
   logic                           wen_q, wen_d;
   logic [REG_ADDR_W-1:0]          wreg_q, wreg_d;
   logic [DATA_W-1:0]              wdata_q, wdata_d;
   logic [NUM_REGS-1:0]            busy_q, busy_d;
   logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_d;

   logic run;
   logic disp_eff;
   logic com_eff;
   logic com_match;
   logic lk1_fwd, lk2_fwd;

   // Ready/init_done go high one cycle after the FSM enters RUN, so the cycle
   // carrying the last sweep write still ignores dispatch/commit/flush.
   assign run = init_done_q;

   // Dispatch under flush is dropped; reg 0 never takes a producer.
   assign disp_eff  = run & bus.dispatch_valid & (bus.dispatch_reg != '0) & ~bus.flush;
   // Commit is older than any same-cycle flush, so it always completes.
   assign com_eff   = run & bus.commit_valid & (bus.commit_reg != '0);
   assign com_match = com_eff & busy_q[bus.commit_reg]
                      & (tag_q[bus.commit_reg] == bus.commit_tag);

   // Next-state for the sweep FSM and the registered ARF write port
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      wen_d       = 1'b0;
      wreg_d      = '0;
      wdata_d     = '0;
      case (state_q)
         ST_INIT: begin
            wen_d  = 1'b1;
            wreg_d = cnt_q;
            if (cnt_q == LAST_REG) state_d = ST_RUN;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         ST_RUN: begin
            init_done_d = 1'b1;
            if (com_eff) begin
               wen_d   = 1'b1;
               wreg_d  = bus.commit_reg;
               wdata_d = bus.commit_data;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // FSM state, sweep counter and registered outputs; reset squashes any
   // pending commit write and restarts the sweep at reg 0
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         wen_q       <= 1'b0;
         wreg_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         wen_q       <= wen_d;
         wreg_q      <= wreg_d;
         wdata_q     <= wdata_d;
      end
   end

   // Scoreboard update: flush or tag-matched commit clears, dispatch wins last
   always_comb begin
      busy_d = busy_q;
      tag_d  = tag_q;
      if (run && bus.flush)  busy_d = '0;
      else if (com_match)    busy_d[bus.commit_reg] = 1'b0;
      if (disp_eff) begin
         busy_d[bus.dispatch_reg] = 1'b1;
         tag_d[bus.dispatch_reg]  = bus.dispatch_tag;
      end
   end

   // Scoreboard state; all busy/tag cleared on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         tag_q  <= '0;
      end else begin
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

`ifdef ARF_COMMIT_BYPASS_EN
   // Forward a matching commit unless a same-cycle dispatch re-claims the reg.
   assign lk1_fwd = com_match & (bus.lookup_reg1 == bus.commit_reg)
                    & ~(disp_eff & (bus.dispatch_reg == bus.lookup_reg1));
   assign lk2_fwd = com_match & (bus.lookup_reg2 == bus.commit_reg)
                    & ~(disp_eff & (bus.dispatch_reg == bus.lookup_reg2));
`else
   assign lk1_fwd = 1'b0;
   assign lk2_fwd = 1'b0;
`endif

   // Reg 0 is hardwired: never busy, tag 0.
   assign bus.lookup_busy1 = (bus.lookup_reg1 != '0) & busy_q[bus.lookup_reg1] & ~lk1_fwd;
   assign bus.lookup_busy2 = (bus.lookup_reg2 != '0) & busy_q[bus.lookup_reg2] & ~lk2_fwd;
   assign bus.lookup_tag1  = (bus.lookup_reg1 != '0) ? tag_q[bus.lookup_reg1] : '0;
   assign bus.lookup_tag2  = (bus.lookup_reg2 != '0) ? tag_q[bus.lookup_reg2] : '0;

   assign bus.dispatch_ready   = init_done_q;
   assign bus.commit_ready     = init_done_q;
   assign bus.init_done        = init_done_q;
   assign bus.arf_write_enable = wen_q;
   assign bus.arf_write_reg    = wreg_q;
   assign bus.arf_write_data   = wdata_q;

endmodule

// File: tb/tb_arf_status_ctrl.sv
// Directed bench for arf_status_ctrl: sweep, dispatch/commit, tag matching,
// dispatch-vs-commit priority, flush, reg 0, mid-operation reset.
module tb_arf_status_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   arf_status_ctrl_if bus ();

   arf_status_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.dispatch_valid = 1'b0;
      bus.commit_valid   = 1'b0;
      bus.flush          = 1'b0;
   endtask

   initial begin
      reset              = 1'b1;
      bus.dispatch_valid = 1'b0;
      bus.dispatch_reg   = '0;
      bus.dispatch_tag   = '0;
      bus.commit_valid   = 1'b0;
      bus.commit_reg     = '0;
      bus.commit_tag     = '0;
      bus.commit_data    = '0;
      bus.flush          = 1'b0;
      bus.lookup_reg1    = 4'd5;
      bus.lookup_reg2    = 4'd7;

      // reset state
      tick();
      chk("rst_wen", bus.arf_write_enable, 0);
      chk("rst_wreg", bus.arf_write_reg, 0);
      chk("rst_wdata", bus.arf_write_data, 0);
      chk("rst_done", bus.init_done, 0);
      chk("rst_drdy", bus.dispatch_ready, 0);
      chk("rst_crdy", bus.commit_ready, 0);
      chk("rst_busy1", bus.lookup_busy1, 0);
      chk("rst_tag1", bus.lookup_tag1, 0);

      // sweep with dispatch/commit/flush noise that must be ignored
      reset              = 1'b0;
      bus.dispatch_valid = 1'b1; bus.dispatch_reg = 4'd5; bus.dispatch_tag = 4'd3;
      bus.commit_valid   = 1'b1; bus.commit_reg   = 4'd9; bus.commit_data  = 32'hAAAA;
      for (int k = 0; k < 16; k++) begin
         tick();
         chk("init_wen", bus.arf_write_enable, 1);
         chk("init_wreg", bus.arf_write_reg, k);
         chk("init_wdata", bus.arf_write_data, 0);
         chk("init_done_lo", bus.init_done, 0);
         chk("init_drdy", bus.dispatch_ready, 0);
      end
      idle();
      tick();
      chk("run_done", bus.init_done, 1);
      chk("run_drdy", bus.dispatch_ready, 1);
      chk("run_crdy", bus.commit_ready, 1);
      chk("run_wen_idle", bus.arf_write_enable, 0);
      chk("init_no_busy", bus.lookup_busy1, 0);

      // dispatch reg 5 tag 3, then commit it
      bus.dispatch_valid = 1'b1; bus.dispatch_reg = 4'd5; bus.dispatch_tag = 4'd3;
      tick(); idle();
      chk("d5_busy", bus.lookup_busy1, 1);
      chk("d5_tag", bus.lookup_tag1, 3);
      bus.commit_valid = 1'b1; bus.commit_reg = 4'd5; bus.commit_tag = 4'd3;
      bus.commit_data  = 32'hDEADBEEF;
      #1;
`ifdef ARF_COMMIT_BYPASS_EN
      chk("c5_bypass", bus.lookup_busy1, 0);
`else
      chk("c5_nobypass", bus.lookup_busy1, 1);
`endif
      tick(); idle();
      chk("c5_wen", bus.arf_write_enable, 1);
      chk("c5_wreg", bus.arf_write_reg, 5);
      chk("c5_wdata", bus.arf_write_data, 32'hDEADBEEF);
      chk("c5_busy", bus.lookup_busy1, 0);
      tick();
      chk("c5_wen_one", bus.arf_write_enable, 0);

      // stale-tag commit on reg 7
      bus.dispatch_valid = 1'b1; bus.dispatch_reg = 4'd7; bus.dispatch_tag = 4'd2;
      tick();
      bus.dispatch_tag = 4'd9;
      tick(); idle();
      bus.commit_valid = 1'b1; bus.commit_reg = 4'd7; bus.commit_tag = 4'd2;
      bus.commit_data  = 32'h11;
      tick(); idle();
      chk("c7s_wen", bus.arf_write_enable, 1);
      chk("c7s_wreg", bus.arf_write_reg, 7);
      chk("c7s_wdata", bus.arf_write_data, 32'h11);
      chk("c7s_busy", bus.lookup_busy2, 1);
      chk("c7s_tag", bus.lookup_tag2, 9);
      bus.commit_valid = 1'b1; bus.commit_reg = 4'd7; bus.commit_tag = 4'd9;
      bus.commit_data  = 32'h22;
      tick(); idle();
      chk("c7_busy", bus.lookup_busy2, 0);
      chk("c7_wdata", bus.arf_write_data, 32'h22);

      // same-cycle dispatch and commit on reg 4: dispatch wins
      bus.lookup_reg1    = 4'd4;
      bus.dispatch_valid = 1'b1; bus.dispatch_reg = 4'd4; bus.dispatch_tag = 4'd6;
      tick();
      bus.dispatch_tag = 4'd1;
      bus.commit_valid = 1'b1; bus.commit_reg = 4'd4; bus.commit_tag = 4'd6;
      bus.commit_data  = 32'h44;
      #1;
      chk("dc4_same_busy", bus.lookup_busy1, 1);
      chk("dc4_same_tag", bus.lookup_tag1, 6);
      tick(); idle();
      chk("dc4_busy", bus.lookup_busy1, 1);
      chk("dc4_tag", bus.lookup_tag1, 1);
      chk("dc4_wen", bus.arf_write_enable, 1);
      chk("dc4_wreg", bus.arf_write_reg, 4);

      // flush with same-cycle dispatch (dropped) and commit (kept)
      bus.dispatch_valid = 1'b1; bus.dispatch_reg = 4'd2; bus.dispatch_tag = 4'd1;
      tick();
      bus.dispatch_reg = 4'd3; bus.dispatch_tag = 4'd2;
      tick();
      bus.dispatch_reg = 4'd8; bus.dispatch_tag = 4'd3;
      tick(); idle();
      bus.lookup_reg1 = 4'd8; bus.lookup_reg2 = 4'd2;
      #1;
      chk("pre_fl_b8", bus.lookup_busy1, 1);
      chk("pre_fl_b2", bus.lookup_busy2, 1);
      bus.flush          = 1'b1;
      bus.dispatch_valid = 1'b1; bus.dispatch_reg = 4'd9; bus.dispatch_tag = 4'd5;
      bus.commit_valid   = 1'b1; bus.commit_reg   = 4'd2; bus.commit_tag   = 4'd7;
      bus.commit_data    = 32'h55;
      tick(); idle();
      chk("fl_wen", bus.arf_write_enable, 1);
      chk("fl_wreg", bus.arf_write_reg, 2);
      chk("fl_wdata", bus.arf_write_data, 32'h55);
      chk("fl_b8", bus.lookup_busy1, 0);
      chk("fl_b2", bus.lookup_busy2, 0);
      bus.lookup_reg1 = 4'd9; bus.lookup_reg2 = 4'd3;
      #1;
      chk("fl_b9", bus.lookup_busy1, 0);
      chk("fl_b3", bus.lookup_busy2, 0);
      bus.lookup_reg1 = 4'd4;
      #1;
      chk("fl_b4", bus.lookup_busy1, 0);

      // register 0 is hardwired
      bus.lookup_reg1    = 4'd0;
      bus.dispatch_valid = 1'b1; bus.dispatch_reg = 4'd0; bus.dispatch_tag = 4'd5;
      tick(); idle();
      chk("r0_busy", bus.lookup_busy1, 0);
      chk("r0_tag", bus.lookup_tag1, 0);
      chk("r0_d_wen", bus.arf_write_enable, 0);
      bus.commit_valid = 1'b1; bus.commit_reg = 4'd0; bus.commit_tag = 4'd0;
      bus.commit_data  = 32'h99;
      tick(); idle();
      chk("r0_c_wen", bus.arf_write_enable, 0);

      // reset during a commit: write squashed, sweep restarts
      bus.lookup_reg1    = 4'd6;
      bus.dispatch_valid = 1'b1; bus.dispatch_reg = 4'd6; bus.dispatch_tag = 4'd4;
      tick(); idle();
      chk("r6_busy", bus.lookup_busy1, 1);
      bus.commit_valid = 1'b1; bus.commit_reg = 4'd6; bus.commit_tag = 4'd4;
      bus.commit_data  = 32'h66;
      reset = 1'b1;
      tick(); idle();
      reset = 1'b0;
      chk("mr_wen", bus.arf_write_enable, 0);
      chk("mr_done", bus.init_done, 0);
      chk("mr_busy", bus.lookup_busy1, 0);
      tick();
      chk("mr_sw0_wen", bus.arf_write_enable, 1);
      chk("mr_sw0_reg", bus.arf_write_reg, 0);
      tick();
      chk("mr_sw1_reg", bus.arf_write_reg, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
